timer_loader: RTL and testbench

Front-end controller for the microwave countdown timer. Collects keypad digits into a shift register, checks the entered time, and loads it into the BCD down-counter chain using that chain's active-low parallel-load interface. It then gates one count-enable pulse per 1 Hz tick until the chain reports zero. It sits between the keypad decoder and the mod-10/mod-6 counter chain, and drives the chain's `input_number` and `loadn` ports and its enable.

---
 rtl/timer_loader.sv | 112 +++++++++++
 tb/tb_timer_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_loader.sv
// timer_loader: keypad entry, validation and load/run sequencing for the
// BCD countdown chain. Optional buzzer phase when TIMER_BEEP_EN is defined.
// Ports: clock, reset (async, high); key_valid, key_digit, start_key,
// clear_key, tick_1hz, timer_zero in; load_number, loadn, count_enable,
// running, done, err, beep out. count_enable is the only combinational out.
module timer_loader #(
  parameter int         DIGITS       = 4,
  parameter logic [3:0] SEC_TENS_MAX = 4'd5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_digit,
  input  logic                  start_key,
  input  logic                  clear_key,
  input  logic                  tick_1hz,
  input  logic                  timer_zero,
  output logic [4*DIGITS-1:0]   load_number,
  output logic                  loadn,
  output logic                  count_enable,
  output logic                  running,
  output logic                  done,
  output logic                  err,
  output logic                  beep
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ARM, RUN, DONE
  } state_t;

  state_t state, next;
  logic   start_ok;
  logic   reject;
  logic   beep_last;

  assign start_ok = (load_number != '0) &&
                    (load_number[7:4] <= SEC_TENS_MAX);

`ifdef TIMER_BEEP_EN
  logic [1:0] beep_ticks;

  // Third tick seen while in DONE ends the buzzer phase.
  assign beep_last = tick_1hz && (beep_ticks == 2'd2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beep       <= 1'b0;
      beep_ticks <= '0;
    end else begin
      beep <= (next == DONE);
      if (state == DONE)
        beep_ticks <= beep_ticks + {1'b0, tick_1hz};
      else
        beep_ticks <= '0;
    end
  end
`else
  assign beep_last = 1'b0;
  assign beep      = 1'b0;
`endif

  always_comb begin
    next         = state;
    reject       = 1'b0;
    count_enable = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_key && !clear_key) begin
          if (start_ok) next = LOAD;
          else          reject = 1'b1;
        end
      end
      LOAD: next = ARM;
      ARM:  next = RUN;
      RUN: begin
        // Gated in RUN only, so it can never overlap loadn low.
        count_enable = tick_1hz && !timer_zero;
        if (clear_key)       next = IDLE;
        else if (timer_zero) next = DONE;
      end
      DONE: begin
        if (clear_key || key_valid) next = IDLE;
        else if (beep_last)         next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      load_number <= '0;
      loadn       <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state   <= next;
      loadn   <= (next != LOAD);
      running <= (next == RUN);
      done    <= (next == DONE);
      err     <= reject;
      if (state == IDLE) begin
        if (clear_key)
          load_number <= '0;
        else if (key_valid && key_digit <= 4'd9)
          load_number <= {load_number[4*DIGITS-5:0], key_digit};
      end
    end
  end

endmodule

// File: tb/tb_timer_loader.sv
// Self-checking bench for timer_loader: entry table, hand sequences for
// load/run/done/reset, then random stimulus against a decimal model.
module tb_timer_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        start_key = 1'b0;
  logic        clear_key = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        timer_zero;
  logic [15:0] load_number;
  logic        loadn, count_enable, running, done, err, beep;

  int errors = 0;
  int checks = 0;

  // Ideal mm:ss chain kept as whole seconds.
  int   chain_sec = 0;
  logic zero_force = 1'b0;
  assign timer_zero = (chain_sec == 0) || zero_force;

  timer_loader dut (
    .clock(clock), .reset(reset),
    .key_valid(key_valid), .key_digit(key_digit),
    .start_key(start_key), .clear_key(clear_key),
    .tick_1hz(tick_1hz), .timer_zero(timer_zero),
    .load_number(load_number), .loadn(loadn),
    .count_enable(count_enable), .running(running),
    .done(done), .err(err), .beep(beep)
  );

  always #5 clock = ~clock;

  function automatic int secs(logic [15:0] b);
    return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 +
           int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] bcd(int e);
    return {4'(e / 1000), 4'((e / 100) % 10),
            4'((e / 10) % 10), 4'(e % 10)};
  endfunction

  always @(posedge clock) begin
    if (!loadn)
      chain_sec <= secs(load_number);
    else if (count_enable && chain_sec > 0)
      chain_sec <= chain_sec - 1;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({load_number, loadn, count_enable,
                running, done, err, beep});
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    key_valid = 1'b0; start_key = 1'b0; clear_key = 1'b0;
    tick_1hz = 1'b0; zero_force = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic press(logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    @(posedge clock); #1;
    key_valid = 1'b0;
  endtask

  task automatic start();
    start_key = 1'b1;
    @(posedge clock); #1;
    start_key = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic        kv;
    logic [3:0]  kd;
    logic        st;
    logic        cl;
    logic [15:0] ln;
    logic        er;
  } vec_t;

  vec_t vt[17];

  localparam int M_IDLE = 0, M_LOAD = 1, M_ARM = 2, M_RUN = 3, M_DONE = 4;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses, last_pulse, done_cyc, nt;
    int mode, entry, err_e, bt;
    logic [31:0] exp;
    logic kv, st, cl;
    logic [3:0] kd;

    vt[0]  = '{1'b1, 4'd1,  1'b0, 1'b0, 16'h0001, 1'b0};
    vt[1]  = '{1'b1, 4'd3,  1'b0, 1'b0, 16'h0013, 1'b0};
    vt[2]  = '{1'b1, 4'd0,  1'b0, 1'b0, 16'h0130, 1'b0};
    vt[3]  = '{1'b1, 4'hB,  1'b0, 1'b0, 16'h0130, 1'b0};
    vt[4]  = '{1'b0, 4'd0,  1'b0, 1'b1, 16'h0000, 1'b0};
    vt[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 1'b1};
    vt[6]  = '{1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b0};
    vt[7]  = '{1'b1, 4'd7,  1'b0, 1'b0, 16'h0007, 1'b0};
    vt[8]  = '{1'b1, 4'd0,  1'b0, 1'b0, 16'h0070, 1'b0};
    vt[9]  = '{1'b0, 4'd0,  1'b1, 1'b0, 16'h0070, 1'b1};
    vt[10] = '{1'b1, 4'd1,  1'b0, 1'b0, 16'h0701, 1'b0};
    vt[11] = '{1'b1, 4'd2,  1'b0, 1'b0, 16'h7012, 1'b0};
    vt[12] = '{1'b1, 4'd3,  1'b0, 1'b0, 16'h0123, 1'b0};
    vt[13] = '{1'b1, 4'd4,  1'b0, 1'b0, 16'h1234, 1'b0};
    vt[14] = '{1'b1, 4'd5,  1'b0, 1'b0, 16'h2345, 1'b0};
    vt[15] = '{1'b1, 4'hB,  1'b0, 1'b0, 16'h2345, 1'b0};
    vt[16] = '{1'b1, 4'hF,  1'b0, 1'b0, 16'h2345, 1'b0};

    // Reset state.
    do_reset();
    @(negedge clock);
    chk("reset", outs(), 32'({16'h0, 6'b100000}));

    // Entry table: idle-state behaviour.
    for (int i = 0; i < 17; i++) begin
      key_valid = vt[i].kv; key_digit = vt[i].kd;
      start_key = vt[i].st; clear_key = vt[i].cl;
      @(posedge clock); #1;
      key_valid = 1'b0; start_key = 1'b0; clear_key = 1'b0;
      @(negedge clock);
      chk($sformatf("vec%0d", i),
          32'({load_number, err, loadn, running}),
          32'({vt[i].ln, vt[i].er, 1'b1, 1'b0}));
    end

    // Entry and load timing, then clear in RUN with timer_zero.
    do_reset();
    press(4'd1); press(4'd3); press(4'd0);
    tick_1hz = 1'b1;
    start();
    @(negedge clock);
    chk("load_n1", outs(), 32'({16'h0130, 6'b000000}));
    next_cycle(); @(negedge clock);
    chk("arm_n2", outs(), 32'({16'h0130, 6'b100000}));
    next_cycle(); @(negedge clock);
    chk("run_n3", outs(), 32'({16'h0130, 6'b111000}));
    next_cycle();
    clear_key = 1'b1; zero_force = 1'b1;
    next_cycle();
    clear_key = 1'b0; zero_force = 1'b0;
    @(negedge clock);
    chk("clear_run", outs(), 32'({16'h0130, 6'b100000}));
    start();
    @(negedge clock);
    chk("reload_n1", 32'({loadn, count_enable}), 32'(2'b00));
    next_cycle(); @(negedge clock);
    chk("reload_val", 32'(chain_sec), 32'(90));
    tick_1hz = 1'b0;

    // Countdown from 00:03 with a tick every 10 cycles.
    do_reset();
    press(4'd3);
    start();
    pulses = 0; last_pulse = -100; done_cyc = -1;
    for (int c = 0; c < 300; c++) begin
      tick_1hz = (c % 10 == 9);
      @(negedge clock);
      if (count_enable) begin pulses++; last_pulse = c; end
      if (done) begin done_cyc = c; break; end
      next_cycle();
    end
    chk("cd_done_seen", 32'(done_cyc >= 0), 32'(1));
    chk("cd_pulses", 32'(pulses), 32'(3));
    chk("cd_done_lat", 32'(done_cyc - last_pulse), 32'(2));
    next_cycle();

`ifdef TIMER_BEEP_EN
    chk("beep_on", 32'(beep), 32'(1));
    nt = 0;
    for (int c = 0; c < 100; c++) begin
      tick_1hz = (c % 10 == 4);
      @(negedge clock);
      if (!done) break;
      if (tick_1hz) nt++;
      next_cycle();
    end
    tick_1hz = 1'b0;
    chk("beep_ticks", 32'(nt), 32'(3));
    chk("beep_auto_idle", 32'({done, beep, running}), 32'(3'b000));
    next_cycle();
    press(4'd7);
    @(negedge clock);
    chk("after_beep_key", 32'(load_number), 32'(16'h0037));
`else
    nt = 0;
    for (int c = 0; c < 30; c++) begin
      tick_1hz = (c % 10 == 4);
      @(negedge clock);
      if (done && !beep) nt++;
      next_cycle();
    end
    tick_1hz = 1'b0;
    chk("done_hold", 32'(nt), 32'(30));
    press(4'd7);
    @(negedge clock);
    chk("done_key_exit", 32'({load_number, done}), 32'({16'h0003, 1'b0}));
`endif

    // Asynchronous reset during LOAD and during RUN.
    do_reset();
    press(4'd5);
    start();
    @(negedge clock); #1;
    reset = 1'b1; #1;
    chk("areset_load", outs(), 32'({16'h0, 6'b100000}));
    next_cycle();
    reset = 1'b0;
    press(4'd5);
    start();
    next_cycle(); next_cycle();
    tick_1hz = 1'b1;
    @(negedge clock);
    chk("pre_areset_run", 32'({running, count_enable}), 32'(2'b11));
    #1; reset = 1'b1; #1;
    chk("areset_run", outs(), 32'({16'h0, 6'b100000}));
    next_cycle();
    tick_1hz = 1'b0;

    // Random stimulus against a decimal reference model.
    do_reset();
    mode = M_IDLE; entry = 0; err_e = 0; bt = 0;
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      kv = (r < 30); st = (r >= 30 && r < 42); cl = (r >= 42 && r < 46);
      kd = (r < 20) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      key_valid = kv; key_digit = kd; start_key = st; clear_key = cl;
      tick_1hz = ($urandom_range(0, 3) == 0);
      @(negedge clock);
      exp = 32'({bcd(entry), mode != M_LOAD,
                 mode == M_RUN && tick_1hz && !timer_zero,
                 mode == M_RUN, mode == M_DONE, err_e[0],
`ifdef TIMER_BEEP_EN
                 mode == M_DONE
`else
                 1'b0
`endif
                 });
      chk($sformatf("rand%0d", c), outs(), exp);
      err_e = 0;
      case (mode)
        M_IDLE: begin
          if (cl) entry = 0;
          else if (kv) begin
            if (kd < 10) entry = (entry * 10 + int'(kd)) % 10000;
          end else if (st) begin
            if (entry != 0 && (entry / 10) % 10 <= 5) mode = M_LOAD;
            else err_e = 1;
          end
        end
        M_LOAD: mode = M_ARM;
        M_ARM:  mode = M_RUN;
        M_RUN: begin
          if (cl) mode = M_IDLE;
          else if (timer_zero) begin mode = M_DONE; bt = 0; end
        end
        default: begin
          if (cl || kv) mode = M_IDLE;
`ifdef TIMER_BEEP_EN
          else if (tick_1hz) begin
            bt++;
            if (bt == 3) mode = M_IDLE;
          end
`endif
        end
      endcase
      next_cycle();
    end
    key_valid = 1'b0; start_key = 1'b0; clear_key = 1'b0; tick_1hz = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
